// File: rtl/mips_pkg.sv
// Shared MIPS control encodings and pipeline control bundles for pipe_controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    // Bundle carried from D into E; an all-zero value is a bubble.
    typedef struct packed {
        logic      valid;
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_write;
        logic      alu_src;
        logic      reg_dst;
        alu_ctrl_e alu_control;
    } ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    function automatic mem_ctrl_t to_mem(input ctrl_t c);
        return '{valid: c.valid, reg_write: c.reg_write,
                 mem_to_reg: c.mem_to_reg, mem_write: c.mem_write};
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t c);
        return '{valid: c.valid, reg_write: c.reg_write, mem_to_reg: c.mem_to_reg};
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational D-stage decoder: opcode/funct to control bundle, branch/jump/illegal flags.
// Optional j support is enabled by defining PIPE_CONTROLLER_JUMP_EN.
module main_decoder
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    output ctrl_t          ctrl,
    output logic           branch,
    output logic           jump,
    output logic           illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        ctrl    = '0;
        branch  = 1'b0;
        jump    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPW'(OP_RTYPE): begin
                ctrl.valid     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    OPW'(FN_ADD): ctrl.alu_control = ALU_ADD;
                    OPW'(FN_SUB): ctrl.alu_control = ALU_SUB;
                    OPW'(FN_AND): ctrl.alu_control = ALU_AND;
                    OPW'(FN_OR):  ctrl.alu_control = ALU_OR;
                    OPW'(FN_SLT): ctrl.alu_control = ALU_SLT;
                    default:      illegal = 1'b1;
                endcase
            end
            OPW'(OP_LW): begin
                ctrl.valid       = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OPW'(OP_SW): begin
                ctrl.valid       = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OPW'(OP_BEQ): begin
                ctrl.valid       = 1'b1;
                ctrl.alu_control = ALU_SUB;
                branch           = 1'b1;
            end
            OPW'(OP_ADDI): begin
                ctrl.valid       = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
`ifdef PIPE_CONTROLLER_JUMP_EN
            OPW'(OP_J): begin
                ctrl.valid = 1'b1;
                jump       = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase

        // An illegal encoding must not leak any partially set control.
        if (illegal) begin
            ctrl   = '0;
            branch = 1'b0;
            jump   = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS controller: D-stage decode, E/M/W control registers, retired-instruction counter.
// Define PIPE_CONTROLLER_JUMP_EN to decode opcode 000010 as j.
module pipe_controller
    import mips_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  OpcodeD,
    input  logic [OPW-1:0]  FunctD,
    input  logic            EqualD,
    input  logic            FlushE,
    output logic            PCSrcD,
    output logic            BranchD,
    output logic            JumpD,
    output logic            IllegalD,
    output logic            RegWriteE,
    output logic            MemToRegE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            RegDstE,
    output logic [2:0]      ALUControlE,
    output logic            RegWriteM,
    output logic            MemToRegM,
    output logic            MemWriteM,
    output logic            RegWriteW,
    output logic            MemToRegW,
    output logic [CNTW-1:0] InstrCountW
);

    ctrl_t           dec_ctrl;
    ctrl_t           e_d, e_q;
    mem_ctrl_t       m_d, m_q;
    wb_ctrl_t        w_d, w_q;
    logic [CNTW-1:0] cnt_d, cnt_q;

    main_decoder #(.OPW(OPW)) u_main_decoder (
        .opcode  (OpcodeD),
        .funct   (FunctD),
        .ctrl    (dec_ctrl),
        .branch  (BranchD),
        .jump    (JumpD),
        .illegal (IllegalD)
    );

    assign PCSrcD = (BranchD & EqualD) | JumpD;

    always_comb begin
        e_d   = FlushE ? '0 : dec_ctrl;
        m_d   = to_mem(e_q);
        w_d   = to_wb(m_q);
        cnt_d = cnt_q + CNTW'(w_q.valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign RegWriteE   = e_q.reg_write;
    assign MemToRegE   = e_q.mem_to_reg;
    assign MemWriteE   = e_q.mem_write;
    assign ALUSrcE     = e_q.alu_src;
    assign RegDstE     = e_q.reg_dst;
    assign ALUControlE = e_q.alu_control;
    assign RegWriteM   = m_q.reg_write;
    assign MemToRegM   = m_q.mem_to_reg;
    assign MemWriteM   = m_q.mem_write;
    assign RegWriteW   = w_q.reg_write;
    assign MemToRegW   = w_q.mem_to_reg;
    assign InstrCountW = cnt_q;

endmodule
